uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Next-generation UART receiver: oversampled serial-to-parallel conversion with runtime parity and stop-bit config.
//  Adds 3-sample majority vote, false-start rejection, break detection and an output FIFO with valid/ready.
//  Sits between the RX pin synchroniser domain (CLK_RX = baud*PRESCALE) and the parallel consumer.
// PARAMETERS
//  WIDTH    8  data bits per frame (5..9), LSB first on the line
//  DEPTH    4  output FIFO entries (power of 2, >=2)
//  PRESC_W  6  width of PRESCALE port
// PORTS
//  CLK_RX         in   1              oversampling clock, PRESCALE cycles per bit
//  RST_RX         in   1              asynchronous reset, active low
//  RX_IN          in   1              serial line, idle high (asynchronous to CLK_RX)
//  PRESCALE       in   PRESC_W        oversampling ratio; legal values 8, 16, 32
//  PAR_EN         in   1              1 = parity bit present after data
//  PAR_TYP        in   1              0 = even, 1 = odd
//  STP2           in   1              1 = two stop bits
//  rx_ready       in   1              consumer accepts FIFO head
//  ovr_clr        in   1              clears sticky ovr_err
//  P_DATA_RX      out  WIDTH          FIFO head data
//  DATA_VALID_RX  out  1              FIFO not empty; head fields valid
//  par_err        out  1              head frame parity mismatch
//  stp_err        out  1              head frame stop bit sampled 0
//  brk_det        out  1              head frame is a line break
//  ovr_err        out  1              sticky: a frame was dropped due to a full FIFO
//  fifo_level     out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, 2-flop RX_IN synchroniser set to 1.
//  Bit timing: edge_cnt 0..P-1 per bit; samples at P/2-1, P/2, P/2+1; majority of 3 = bit value.
//  PRESCALE/PAR_EN/PAR_TYP/STP2 latched on IDLE->START; changes mid-frame affect the next frame only.
//  FSM: IDLE -> START on synchronised RX_IN==0 (edge_cnt cleared to 1).
//   START: voted 1 -> IDLE (glitch, nothing pushed); voted 0 -> DATA at edge_cnt==P-1.
//   DATA: WIDTH bits, shift LSB first; -> PARITY if PAR_EN else STOP.
//   PARITY: expected = ^data (even) / ~^data (odd); mismatch sets frame par flag.
//   STOP: voted 0 sets frame stp flag; if STP2 -> STOP2 (same check, flags OR'd).
//   Last stop bit: push at cycle after its 3rd sample (edge_cnt==P/2+2), then IDLE; allows back-to-back frames.
//  Break: data all 0, parity bit (if present) 0, first stop 0 -> brk=1, stp=1, data=0; FSM -> BRK_WAIT
//   until synchronised RX_IN==1, then IDLE. Exactly one entry pushed per break.
//  Latency: pushed entry appears on DATA_VALID_RX/P_DATA_RX the next CLK_RX edge.
//  FIFO entry = {brk, par, stp, data}; errored frames are pushed, not discarded.
//  Pop when DATA_VALID_RX && rx_ready; head advances next edge.
//  Push while full: frame dropped, ovr_err=1 until ovr_clr (ovr_clr and new overrun same cycle -> stays 1).
//  Push+pop same cycle when full: both accepted, level unchanged, no overrun. Empty: rx_ready ignored.
//  Pointers wrap modulo DEPTH; fifo_level in 0..DEPTH.
//  Illegal PRESCALE: behaviour undefined, must not hang FSM past next IDLE line.
// TESTING
//  P=8, no parity, 1 stop, send 0xAB, rx_ready=1 -> one beat P_DATA_RX=0xAB, all error flags 0.
//  P=16, PAR_EN=1 odd, send 0xBB with wrong parity bit -> P_DATA_RX=0xBB, par_err=1, stp_err=0.
//  P=32, STP2=1, send 0x98 with 2nd stop bit=0 -> stp_err=1; 2-cycle (<P/2) low glitch on idle line -> no push.
//  Line held low 12 bit times at P=16 -> single entry data=0, brk_det=1, stp_err=1; next 0x55 received cleanly.
//  rx_ready=0, send DEPTH+1 frames 0x01.. -> fifo_level=DEPTH, ovr_err=1, last frame lost; drain yields 0x01..0x04.
//  Assert RST_RX low mid-DATA of 0xFC -> outputs 0, FIFO empty; following frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Parallel output stream of the UART receiver: FIFO head fields plus valid/ready handshake.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA_RX;
  logic             DATA_VALID_RX;
  logic             par_err;
  logic             stp_err;
  logic             brk_det;
  logic             rx_ready;

  modport master (
    output P_DATA_RX, DATA_VALID_RX, par_err, stp_err, brk_det,
    input  rx_ready
  );

  modport slave (
    input  P_DATA_RX, DATA_VALID_RX, par_err, stp_err, brk_det,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, false-start rejection,
// break detection and an output FIFO carrying per-frame error flags.
module uart_rx_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int PRESC_W = 6
) (
  input  logic                     CLK_RX,
  input  logic                     RST_RX,
  input  logic                     RX_IN,
  input  logic [PRESC_W-1:0]       PRESCALE,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic                     STP2,
  input  logic                     ovr_clr,
  uart_rx_fifo_if.master           rx_if,
  output logic                     ovr_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WIDTH + 3;
  localparam int BW = $clog2(WIDTH);
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_BRK_WAIT
  } state_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic exp_parity(input logic [WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [1:0]          sync_q;
  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  edge_q, edge_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [2:0]          smp_q, smp_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                par_bit_q, par_bit_d;
  logic                par_flag_q, par_flag_d;
  logic                stp_flag_q, stp_flag_d;
  logic [PRESC_W-1:0]  presc_q;
  logic                pen_q, ptyp_q, stp2_q;
  logic                cfg_load_s;
  logic                push_s;
  logic [EW-1:0]       entry_s;

  logic                rx_sync_s, vote_s, at_last_s, at_dec_s;
  logic [PRESC_W-1:0]  half_s;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       cnt_q;
  logic                ovr_q;
  logic                full_s, valid_s, pop_s, wr_en_s, ovr_set_s;
  logic [EW-1:0]       head_s;

  assign rx_sync_s = sync_q[1];
  assign vote_s    = maj3(smp_q);
  assign half_s    = presc_q >> 1;
  assign at_last_s = (edge_q == presc_q - ONE);
  assign at_dec_s  = (edge_q == half_s + PRESC_W'(2));

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  // Receiver FSM state and frame datapath registers
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      smp_q      <= 3'b111;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      presc_q    <= PRESC_W'(8);
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      stp2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      if (cfg_load_s) begin
        // Ratios below 8 would leave no room for the decision point; clamp them.
        presc_q <= (PRESCALE < PRESC_W'(8)) ? PRESC_W'(8) : PRESCALE;
        pen_q   <= PAR_EN;
        ptyp_q  <= PAR_TYP;
        stp2_q  <= STP2;
      end else begin
        presc_q <= presc_q;
        pen_q   <= pen_q;
        ptyp_q  <= ptyp_q;
        stp2_q  <= stp2_q;
      end
    end
  end

  // Next-state, bit sampling and push decision
  always_comb begin
    state_d    = state_q;
    edge_d     = at_last_s ? '0 : edge_q + ONE;
    bit_d      = bit_q;
    smp_d      = smp_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    cfg_load_s = 1'b0;
    push_s     = 1'b0;
    entry_s    = {1'b0, par_flag_q, stp_flag_q | ~vote_s, data_q};

    if (edge_q == half_s - ONE) begin
      smp_d[0] = rx_sync_s;
    end else if (edge_q == half_s) begin
      smp_d[1] = rx_sync_s;
    end else if (edge_q == half_s + ONE) begin
      smp_d[2] = rx_sync_s;
    end else begin
      smp_d = smp_q;
    end

    case (state_q)
      S_IDLE: begin
        edge_d = '0;
        if (!rx_sync_s) begin
          state_d    = S_START;
          edge_d     = ONE;
          cfg_load_s = 1'b1;
          bit_d      = '0;
          smp_d      = 3'b111;
          par_bit_d  = 1'b0;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (at_dec_s && vote_s) begin
          state_d = S_IDLE;
        end else if (at_last_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (at_last_s) begin
          data_d = {vote_s, data_q[WIDTH-1:1]};
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (at_last_s) begin
          par_bit_d  = vote_s;
          par_flag_d = (vote_s != exp_parity(data_q, ptyp_q));
          state_d    = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (at_dec_s) begin
          if (!vote_s && (data_q == '0) && !par_bit_q) begin
            push_s  = 1'b1;
            entry_s = {1'b1, par_flag_q, 1'b1, {WIDTH{1'b0}}};
            state_d = S_BRK_WAIT;
          end else if (!stp2_q) begin
            push_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stp_flag_d = stp_flag_q | ~vote_s;
          end
        end else if (at_last_s && stp2_q) begin
          state_d = S_STOP2;
        end else begin
          state_d = S_STOP;
        end
      end
      S_STOP2: begin
        if (at_dec_s) begin
          push_s  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP2;
        end
      end
      S_BRK_WAIT: begin
        edge_d = '0;
        if (rx_sync_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BRK_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign valid_s   = (cnt_q != '0);
  assign full_s    = (cnt_q == LW'(DEPTH));
  assign pop_s     = valid_s && rx_if.rx_ready;
  assign wr_en_s   = push_s && (!full_s || pop_s);
  assign ovr_set_s = push_s && full_s && !pop_s;
  assign head_s    = mem_q[rd_q];

  // Output FIFO storage, pointers, level and sticky overrun
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_q] <= entry_s;
        wr_q        <= wr_q + AW'(1);
      end else begin
        wr_q <= wr_q;
      end
      rd_q <= pop_s ? rd_q + AW'(1) : rd_q;
      case ({wr_en_s, pop_s})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (ovr_set_s) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end else begin
        ovr_q <= ovr_q;
      end
    end
  end

  // Head fields are forced to zero while the FIFO is empty.
  assign rx_if.DATA_VALID_RX = valid_s;
  assign rx_if.P_DATA_RX     = valid_s ? head_s[WIDTH-1:0] : '0;
  assign rx_if.stp_err       = valid_s & head_s[WIDTH];
  assign rx_if.par_err       = valid_s & head_s[WIDTH+1];
  assign rx_if.brk_det       = valid_s & head_s[WIDTH+2];
  assign ovr_err             = ovr_q;
  assign fifo_level          = cnt_q;

endmodule
